// File: rtl/scoreboard_pkg.sv
// Shared types and helpers for the in-order instruction scoreboard.
package scoreboard_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_W   = 5;

  typedef struct packed {
    logic               valid;
    logic               done;
    logic [INSTR_W-1:0] instr;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
  } entry_t;

  // Circular index add for queues whose depth need not be a power of two.
  function automatic int unsigned wrap_add(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned size);
    int unsigned s;
    s = base + off;
    return (s >= size) ? (s - size) : s;
  endfunction

endpackage

// File: rtl/scoreboard_match.sv
// Age-ordered CAM search: scans from head towards younger entries and reports
// the oldest valid entry whose tag equals key_i, as an offset from head.
module scoreboard_match
  import scoreboard_pkg::*;
#(
  parameter int unsigned SIZE = 16,
  localparam int unsigned PTR_W = $clog2(SIZE)
) (
  input  logic [SIZE-1:0]              valid_i,
  input  logic [SIZE-1:0][INSTR_W-1:0] tag_i,
  input  logic [PTR_W-1:0]             head_i,
  input  logic [INSTR_W-1:0]           key_i,
  output logic                         hit_o,
  output logic [PTR_W-1:0]             offset_o
);

  logic             found;
  logic [PTR_W-1:0] found_off;
  logic [PTR_W-1:0] idx;

  always_comb begin
    found     = 1'b0;
    found_off = '0;
    idx       = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      idx = PTR_W'(wrap_add(32'(head_i), i, SIZE));
      if (!found && valid_i[idx] && (tag_i[idx] == key_i)) begin
        found     = 1'b1;
        found_off = PTR_W'(i);
      end
    end
  end

  assign hit_o    = found;
  assign offset_o = found_off;

endmodule

// File: rtl/scoreboard.sv
// In-order instruction tracking queue between issue and commit.
// Optional macro SCOREBOARD_FINISH_BYPASS_EN: a same-cycle finish of the head
// tag makes head_ready assert combinationally, so start_head can retire it.
module scoreboard
  import scoreboard_pkg::*;
#(
  parameter int unsigned SIZE = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               start_head,
  input  logic               committing_instr,
  input  logic [INSTR_W-1:0] instr_to_finish,
  input  logic               flushing_instr,
  input  logic [INSTR_W-1:0] instr_to_flush,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [REG_W-1:0]   rd_in,
  input  logic [REG_W-1:0]   rs1_in,
  input  logic [REG_W-1:0]   rs2_in,
  output logic               is_full,
  output logic               is_empty,
  output logic [INSTR_W-1:0] head_instr,
  output logic               head_ready
);

  localparam int unsigned PTR_W = $clog2(SIZE);
  localparam int unsigned CNT_W = $clog2(SIZE + 1);

  entry_t             entries_q [SIZE];
  entry_t             entries_d [SIZE];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [SIZE-1:0]              valid_vec;
  logic [SIZE-1:0][INSTR_W-1:0] tag_vec;
  logic                         fin_hit, flu_hit;
  logic [PTR_W-1:0]             fin_off, flu_off;
  logic [PTR_W-1:0]             fin_idx, flu_idx, clr_idx;
  logic                         push_ok, pop_ok, head_done;
  logic                         unused_fields;

  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    valid_vec     = '0;
    tag_vec       = '0;
    unused_fields = 1'b0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      valid_vec[PTR_W'(i)] = entries_q[PTR_W'(i)].valid;
      tag_vec[PTR_W'(i)]   = entries_q[PTR_W'(i)].instr;
      unused_fields = unused_fields ^ (^{entries_q[PTR_W'(i)].rd,
                                         entries_q[PTR_W'(i)].rs1,
                                         entries_q[PTR_W'(i)].rs2});
    end
  end

  scoreboard_match #(.SIZE(SIZE)) u_finish_match (
    .valid_i  (valid_vec),
    .tag_i    (tag_vec),
    .head_i   (head_q),
    .key_i    (instr_to_finish),
    .hit_o    (fin_hit),
    .offset_o (fin_off)
  );

  scoreboard_match #(.SIZE(SIZE)) u_flush_match (
    .valid_i  (valid_vec),
    .tag_i    (tag_vec),
    .head_i   (head_q),
    .key_i    (instr_to_flush),
    .hit_o    (flu_hit),
    .offset_o (flu_off)
  );

  assign fin_idx = PTR_W'(wrap_add(32'(head_q), 32'(fin_off), SIZE));
  assign flu_idx = PTR_W'(wrap_add(32'(head_q), 32'(flu_off), SIZE));

  assign is_empty   = (count_q == '0);
  assign is_full    = (count_q == CNT_W'(SIZE));
  assign head_instr = is_empty ? '0 : entries_q[head_q].instr;
  assign head_done  = !is_empty && entries_q[head_q].valid && entries_q[head_q].done;

`ifdef SCOREBOARD_FINISH_BYPASS_EN
  assign head_ready = head_done ||
                      (!is_empty && committing_instr &&
                       (instr_to_finish == entries_q[head_q].instr));
`else
  assign head_ready = head_done;
`endif

  assign push_ok = push && !is_full && !flushing_instr;
  assign pop_ok  = start_head && !is_empty && head_ready && !flushing_instr;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    clr_idx   = '0;
    if (flushing_instr) begin
      if (flu_hit) begin
        // Everything at or beyond the match offset is younger, so the
        // surviving count equals the offset and the tail snaps back to it.
        for (int unsigned j = 0; j < SIZE; j++) begin
          if (PTR_W'(j) >= flu_off) begin
            clr_idx = PTR_W'(wrap_add(32'(head_q), j, SIZE));
            entries_d[clr_idx].valid = 1'b0;
            entries_d[clr_idx].done  = 1'b0;
          end
        end
        tail_d  = flu_idx;
        count_d = CNT_W'(flu_off);
      end
    end else begin
      if (committing_instr && fin_hit) begin
        entries_d[fin_idx].done = 1'b1;
      end
      if (pop_ok) begin
        entries_d[head_q] = '0;
        head_d            = inc(head_q);
      end
      if (push_ok) begin
        entries_d[tail_q] = '{valid: 1'b1, done: 1'b0, instr: instr_in,
                              rd: rd_in, rs1: rs1_in, rs2: rs2_in};
        tail_d            = inc(tail_q);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entries_q <= '{default: '0};
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_scoreboard.sv
module tb_scoreboard;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        push = 1'b0, start_head = 1'b0, committing_instr = 1'b0, flushing_instr = 1'b0;
  logic [31:0] instr_to_finish = '0, instr_to_flush = '0, instr_in = '0;
  logic [4:0]  rd_in = '0, rs1_in = '0, rs2_in = '0;
  logic        is_full, is_empty, head_ready;
  logic [31:0] head_instr;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  scoreboard #(.SIZE(10)) dut (
    .clock            (clock),
    .reset            (reset),
    .push             (push),
    .start_head       (start_head),
    .committing_instr (committing_instr),
    .instr_to_finish  (instr_to_finish),
    .flushing_instr   (flushing_instr),
    .instr_to_flush   (instr_to_flush),
    .instr_in         (instr_in),
    .rd_in            (rd_in),
    .rs1_in           (rs1_in),
    .rs2_in           (rs2_in),
    .is_full          (is_full),
    .is_empty         (is_empty),
    .head_instr       (head_instr),
    .head_ready       (head_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rstn;
    logic        psh;
    logic [31:0] tag;
    logic        hd;
    logic        fin;
    logic [31:0] ftag;
    logic        flu;
    logic [31:0] xtag;
    logic        ef;
    logic        ee;
    logic [31:0] eh;
    logic        er;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rstn, input logic psh, input int tag,
                     input logic hd, input logic fin, input int ftag,
                     input logic flu, input int xtag,
                     input logic ef, input logic ee, input int eh, input logic er);
    vec_t v;
    v.rstn = rstn; v.psh = psh; v.tag = tag; v.hd = hd; v.fin = fin; v.ftag = ftag;
    v.flu = flu; v.xtag = xtag; v.ef = ef; v.ee = ee; v.eh = eh; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic check_outs(input string name, input logic ef, input logic ee,
                            input logic [31:0] eh, input logic er);
    n_vec++;
    if (is_full !== ef) begin
      n_bad++;
      $display("FAIL %s is_full: got %b want %b", name, is_full, ef);
    end
    if (is_empty !== ee) begin
      n_bad++;
      $display("FAIL %s is_empty: got %b want %b", name, is_empty, ee);
    end
    if (head_instr !== eh) begin
      n_bad++;
      $display("FAIL %s head_instr: got %0d want %0d", name, head_instr, eh);
    end
    if (head_ready !== er) begin
      n_bad++;
      $display("FAIL %s head_ready: got %b want %b", name, head_ready, er);
    end
  endtask

  task automatic idle_inputs();
    push = 1'b0; start_head = 1'b0; committing_instr = 1'b0; flushing_instr = 1'b0;
    instr_in = '0; instr_to_finish = '0; instr_to_flush = '0;
    rd_in = '0; rs1_in = '0; rs2_in = '0;
  endtask

  initial begin
    int drain_tags[9] = '{5, 6, 7, 8, 9, 10, 12, 13, 14};
    string nm;

    // --- basic push / finish / pop ---
    add(1, 0,   0, 0, 0,   0, 0,   0, 0, 1,   0, 0);
    add(1, 1, 100, 0, 0,   0, 0,   0, 0, 0, 100, 0);
    add(1, 1, 101, 0, 0,   0, 0,   0, 0, 0, 100, 0);
    add(1, 1, 102, 0, 0,   0, 0,   0, 0, 0, 100, 0);
    add(1, 0,   0, 1, 0,   0, 0,   0, 0, 0, 100, 0);
    add(1, 0,   0, 0, 1, 101, 0,   0, 0, 0, 100, 0);
    add(1, 0,   0, 0, 1, 100, 0,   0, 0, 0, 100, 1);
    add(1, 0,   0, 1, 0,   0, 0,   0, 0, 0, 101, 1);
    add(1, 0,   0, 1, 0,   0, 0,   0, 0, 0, 102, 0);
    add(1, 0,   0, 0, 1, 102, 0,   0, 0, 0, 102, 1);
    add(1, 0,   0, 1, 0,   0, 0,   0, 0, 1,   0, 0);
    // --- fill, overflow, wrap ---
    add(0, 0,   0, 0, 0,   0, 0,   0, 0, 1,   0, 0);
    for (int k = 1; k <= 10; k++)
      add(1, 1, k, 0, 0, 0, 0, 0, (k == 10), 0, 1, 0);
    add(1, 1,  11, 0, 0,   0, 0,   0, 1, 0,   1, 0);
    add(1, 0,   0, 0, 1,   1, 0,   0, 1, 0,   1, 1);
    add(1, 1,  12, 1, 0,   0, 0,   0, 0, 0,   2, 0);
    add(1, 1,  12, 0, 0,   0, 0,   0, 1, 0,   2, 0);
    add(1, 0,   0, 0, 1,   2, 0,   0, 1, 0,   2, 1);
    add(1, 0,   0, 1, 0,   0, 0,   0, 0, 0,   3, 0);
    add(1, 0,   0, 0, 1,   3, 0,   0, 0, 0,   3, 1);
    add(1, 1,  13, 1, 0,   0, 0,   0, 0, 0,   4, 0);
    add(1, 1,  14, 0, 0,   0, 0,   0, 1, 0,   4, 0);
    add(1, 0,   0, 0, 1,   4, 0,   0, 1, 0,   4, 1);
    foreach (drain_tags[i])
      add(1, 0, 0, 1, 1, drain_tags[i], 0, 0, 0, 0, drain_tags[i], 1);
    add(1, 0,   0, 1, 0,   0, 0,   0, 0, 1,   0, 0);
    // --- flush with simultaneous push/finish ---
    add(0, 0,   0, 0, 0,   0, 0,   0, 0, 1,   0, 0);
    for (int t = 200; t <= 204; t++)
      add(1, 1, t, 0, 0, 0, 0, 0, 0, 0, 200, 0);
    add(1, 1, 250, 0, 1, 200, 1, 202, 0, 0, 200, 0);
    add(1, 1, 205, 0, 0,   0, 0,   0, 0, 0, 200, 0);
    add(1, 0,   0, 0, 1, 200, 0,   0, 0, 0, 200, 1);
    add(1, 0,   0, 1, 1, 201, 0,   0, 0, 0, 201, 1);
    add(1, 0,   0, 1, 1, 205, 0,   0, 0, 0, 205, 1);
    add(1, 0,   0, 1, 0,   0, 0,   0, 0, 1,   0, 0);
    // --- duplicate tags, no-match flush ---
    add(1, 1,   7, 0, 0,   0, 0,   0, 0, 0,   7, 0);
    add(1, 1,   8, 0, 0,   0, 0,   0, 0, 0,   7, 0);
    add(1, 1,   7, 0, 0,   0, 0,   0, 0, 0,   7, 0);
    add(1, 0,   0, 0, 1,   7, 0,   0, 0, 0,   7, 1);
    add(1, 0,   0, 1, 0,   0, 0,   0, 0, 0,   8, 0);
    add(1, 0,   0, 0, 0,   0, 1,   7, 0, 0,   8, 0);
    add(1, 0,   0, 0, 0,   0, 1,  99, 0, 0,   8, 0);
    add(1, 0,   0, 0, 1,   8, 0,   0, 0, 0,   8, 1);
    add(1, 0,   0, 1, 0,   0, 0,   0, 0, 1,   0, 0);
    // --- same-cycle finish of head does not enable the pop ---
    add(1, 1, 300, 0, 0,   0, 0,   0, 0, 0, 300, 0);
    add(1, 0,   0, 1, 1, 300, 0,   0, 0, 0, 300, 1);
    add(1, 0,   0, 1, 0,   0, 0,   0, 0, 1,   0, 0);

    // Reset state with reset held low
    idle_inputs();
    reset = 1'b0;
    #12;
    check_outs("reset_state", 1'b0, 1'b1, 32'd0, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clock);
      reset            = vecs[i].rstn;
      push             = vecs[i].psh;
      instr_in         = vecs[i].tag;
      rd_in            = vecs[i].tag[4:0];
      rs1_in           = vecs[i].tag[9:5];
      rs2_in           = ~vecs[i].tag[4:0];
      start_head       = vecs[i].hd;
      committing_instr = vecs[i].fin;
      instr_to_finish  = vecs[i].ftag;
      flushing_instr   = vecs[i].flu;
      instr_to_flush   = vecs[i].xtag;
      @(posedge clock);
      #1;
      idle_inputs();
      reset = 1'b1;
      #1;
      nm = $sformatf("vec%0d", i);
      check_outs(nm, vecs[i].ef, vecs[i].ee, vecs[i].eh, vecs[i].er);
    end

    // Asynchronous reset mid-stream with five entries held
    for (int t = 400; t < 405; t++) begin
      @(negedge clock);
      push = 1'b1; instr_in = t;
      @(posedge clock);
      #1;
      idle_inputs();
    end
    #1;
    check_outs("five_entries", 1'b0, 1'b0, 32'd400, 1'b0);
    reset = 1'b0;
    #1;
    check_outs("async_reset", 1'b0, 1'b1, 32'd0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_outs("after_reset_edge", 1'b0, 1'b1, 32'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
